// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types, constants and helpers for the bus arbiter
package bus_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int BYTE_EN = 4;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r | (oh[i] ? 3'(i) : 3'd0);
    return r;
  endfunction
endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: rotate-priority picker, first requester after ptr wins
module rr_arb_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);
  // scan backwards so the closest requester after ptr is written last
  always_comb begin
    win = '0;
    for (int i = N; i > 0; i--)
      if (req[(int'(ptr) + i) % N]) win = N'(1) << ((int'(ptr) + i) % N);
    valid = |req;
  end
endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: round-robin N-master arbiter with burst cap and tagged read return
module sys_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int XLEN        = 32,
  parameter int MAX_BURST   = 16,
  parameter int RD_LAT      = 1,
  parameter int IW          = $clog2(NUM_MASTERS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_MASTERS-1:0]         req_i,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  input  logic [NUM_MASTERS*XLEN-1:0]    m_addr_i,
  input  logic [NUM_MASTERS-1:0]         m_write_i,
  input  logic [NUM_MASTERS-1:0]         m_read_i,
  input  logic [NUM_MASTERS*BYTE_EN-1:0] m_size_i,
  input  logic [NUM_MASTERS*XLEN-1:0]    m_din_i,
  output logic [XLEN-1:0]                m_dout_o,
  output logic [NUM_MASTERS-1:0]         m_rvalid_o,
  output logic [XLEN-1:0]                s_addr_o,
  output logic                           s_write_o,
  output logic                           s_read_o,
  output logic [BYTE_EN-1:0]             s_size_o,
  output logic [XLEN-1:0]                s_din_o,
  input  logic [XLEN-1:0]                s_dout_i,
  output logic [IW-1:0]                  owner_o,
  output logic                           busy_o
);
  state_t state, state_n;
  logic [NUM_MASTERS-1:0] gnt_n, win;
  logic [NUM_MASTERS-1:0] tag [RD_LAT];
  logic [IW-1:0] owner_n, ptr, ptr_n;
  logic [7:0] cnt, cnt_n;
  logic valid, own_req, others, cap, act;

  rr_arb_pick #(.N(NUM_MASTERS)) u_pick (.req(req_i), .ptr(ptr), .win(win), .valid(valid));

  // arbitration state register; pointer starts at the last master so master 0 goes first
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state   <= IDLE;
      gnt_o   <= '0;
      owner_o <= '0;
      ptr     <= IW'(NUM_MASTERS - 1);
      cnt     <= '0;
    end else begin
      state   <= state_n;
      gnt_o   <= gnt_n;
      owner_o <= owner_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end

  // grant on any request from IDLE; release on owner drop or capped burst with a waiter
  always_comb begin
    own_req = req_i[owner_o];
    others  = |(req_i & ~gnt_o);
    cap     = cnt == 8'(MAX_BURST - 1);
    state_n = state;
    gnt_n   = gnt_o;
    owner_n = owner_o;
    ptr_n   = ptr;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (valid) begin
        state_n = GRANT;
        gnt_n   = win;
        owner_n = IW'(oh2idx(8'(win)));
        ptr_n   = owner_n;
        cnt_n   = '0;
      end
    end else if (!own_req || (cap && others)) begin
      state_n = IDLE;
      gnt_n   = '0;
    end else cnt_n = cap ? cnt : cnt + 8'd1;
  end

  // slave port follows the owner only while it is both granted and requesting
  always_comb begin
    act       = |(gnt_o & req_i);
    s_addr_o  = act ? m_addr_i[int'(owner_o)*XLEN +: XLEN] : '0;
    s_din_o   = act ? m_din_i[int'(owner_o)*XLEN +: XLEN] : '0;
    s_size_o  = act ? m_size_i[int'(owner_o)*BYTE_EN +: BYTE_EN] : '0;
    s_write_o = act & m_write_i[owner_o];
    s_read_o  = act & m_read_i[owner_o];
  end

  // read tag pipeline carries the issuing master to the data return cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
    else begin
      tag[0] <= s_read_o ? gnt_o : '0;
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
    end

  // busy while granted or any read is still in flight
  always_comb begin
    busy_o = |gnt_o;
    for (int i = 0; i < RD_LAT; i++) busy_o = busy_o | (|tag[i]);
  end

  assign m_rvalid_o = tag[RD_LAT-1];
  assign m_dout_o   = s_dout_i;
endmodule
